// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding word access with LATENCY wait states and a one-cycle response.
// Optional access-error checking (misaligned / out-of-range) is compiled in with `define DMEM_ERR_EN.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
`ifdef DMEM_ERR_EN
    output logic        mem_stall,
    output logic        rsp_err
`else
    output logic        mem_stall
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt;

    logic [31:0] mem [2**ADDR_W];

    logic              we_p0;
    logic [ADDR_W-1:0] idx_p0;
    logic [31:0]       wdata_p0;
    logic              err_p0;

    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic              accept;
    logic              go_resp;
    logic              acc_we;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              mem_we;

    assign req_idx = req_addr[ADDR_W+1:2];

`ifdef DMEM_ERR_EN
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign rsp_err = (state == RESP) && err_p0;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign req_err = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign mem_stall = ((state == IDLE) && req_valid) || (state == WAIT);

    // With zero wait states the response edge is the accept edge, so the live request is used directly.
    assign go_resp   = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));
    assign acc_we    = (state == IDLE) ? req_we    : we_p0;
    assign acc_idx   = (state == IDLE) ? req_idx   : idx_p0;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_p0;
    assign acc_err   = (state == IDLE) ? req_err   : err_p0;
    assign mem_we    = go_resp && acc_we && !acc_err && rst_n;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            err_p0    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= 4'(LATENCY);
                err_p0 <= req_err;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (go_resp)
                rsp_rdata <= (acc_we || acc_err) ? '0 : mem[acc_idx];
        end
    end

    // Request capture and array write: datapath only, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            idx_p0   <= req_idx;
            wdata_p0 <= req_wdata;
        end
        if (mem_we)
            mem[acc_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance driven with the same requests.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, mem_stall;
    logic [31:0] rsp_rdata;
    logic        req_ready0, rsp_valid0, mem_stall0;
    logic [31:0] rsp_rdata0;
`ifdef DMEM_ERR_EN
    logic        rsp_err, rsp_err0;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];
    logic [31:0] sb0_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef DMEM_ERR_EN
        .rsp_err(rsp_err),
`endif
        .mem_stall(mem_stall)
    );

    dmem_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
`ifdef DMEM_ERR_EN
        .rsp_err(rsp_err0),
`endif
        .mem_stall(mem_stall0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access on both instances; expected data queued at drive time, popped on rsp_valid.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input logic [31:0] exp0,
                          input logic err, input string tag);
        int cyc, stall_n, cyc0, stall0;
        bit got, got0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        sb_q.push_back(exp);
        sb0_q.push_back(exp0);
        cyc = 0; stall_n = 0; cyc0 = 0; stall0 = 0; got = 0; got0 = 0;
        while ((!got || !got0) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!got && mem_stall) stall_n++;
            if (!got0 && mem_stall0) stall0++;
            if (rsp_valid) begin
                if (got || sb_q.size() == 0) check({tag, " extra_rsp"}, 32'd1, 32'd0);
                else begin
                    got = 1;
                    check({tag, " rdata"}, rsp_rdata, sb_q.pop_front());
                    check({tag, " lat"}, cyc, 4);
                    check({tag, " stall_cycles"}, stall_n, 3);
`ifdef DMEM_ERR_EN
                    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, err});
`endif
                end
            end
            if (rsp_valid0) begin
                if (got0 || sb0_q.size() == 0) check({tag, " extra_rsp0"}, 32'd1, 32'd0);
                else begin
                    got0 = 1;
                    cyc0 = cyc;
                    check({tag, " rdata0"}, rsp_rdata0, sb0_q.pop_front());
                    check({tag, " stall_cycles0"}, stall0, 1);
`ifdef DMEM_ERR_EN
                    check({tag, " err0"}, {31'd0, rsp_err0}, {31'd0, err});
`endif
                end
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        check({tag, " got_rsp"}, {31'd0, got}, 32'd1);
        if (got0) check({tag, " lat0"}, cyc0, 2);
        else check({tag, " got_rsp0"}, {31'd0, got0}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int acc_cyc[4];
        logic [31:0] b2b_addr[4];
        logic [31:0] b2b_data[4];
        logic        b2b_we[4];
        logic [31:0] b2b_exp[4];
        int k, cyc;
        bit acc_now;

        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h8,   32'h55,       32'h0});
        vecs.push_back('{1'b0, 32'h8,   32'h0,        32'h55});
        vecs.push_back('{1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0});
`ifndef DMEM_ERR_EN
        vecs.push_back('{1'b0, 32'h7FC, 32'h0,        32'hCAFEF00D});
        vecs.push_back('{1'b0, 32'h11,  32'h0,        32'hDEADBEEF});
`endif
        vecs.push_back('{1'b1, 32'h20,  32'hAAAA5555, 32'h0});
        vecs.push_back('{1'b0, 32'h20,  32'h0,        32'hAAAA5555});

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst mem_stall", {31'd0, mem_stall}, 32'd0);
`ifdef DMEM_ERR_EN
        check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle flags", {29'd0, req_ready, mem_stall, rsp_valid}, 32'b100);
        end

        for (int i = 0; i < vecs.size(); i++)
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].exp, 1'b0,
                   $sformatf("vec%0d", i));

        // Back-to-back with req_valid held: accepts only in IDLE, four cycles apart.
        b2b_we   = '{1'b1, 1'b1, 1'b0, 1'b0};
        b2b_addr = '{32'h0, 32'h4, 32'h0, 32'h4};
        b2b_data = '{32'h1, 32'h2, 32'h0, 32'h0};
        b2b_exp  = '{32'h0, 32'h0, 32'h1, 32'h2};
        repeat (3) @(posedge clk);
        #1;
        k = 0; cyc = 0;
        req_valid = 1'b1; req_we = b2b_we[0]; req_addr = b2b_addr[0]; req_wdata = b2b_data[0];
        while ((k < 4 || sb_q.size() > 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            acc_now = 0;
            if (rsp_valid) begin
                if (sb_q.size() == 0) check("b2b extra_rsp", 32'd1, 32'd0);
                else check("b2b rdata", rsp_rdata, sb_q.pop_front());
            end
            if (req_valid) check("b2b stall", {31'd0, mem_stall}, {31'd0, !rsp_valid});
            if (req_valid && req_ready) begin
                acc_cyc[k] = cyc;
                sb_q.push_back(b2b_exp[k]);
                acc_now = 1;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                k++;
                if (k < 4) begin
                    req_we = b2b_we[k]; req_addr = b2b_addr[k]; req_wdata = b2b_data[k];
                end else req_valid = 1'b0;
            end
        end
        check("b2b accepted", k, 4);
        for (int i = 0; i < 3; i++)
            if (i + 1 < k) check("b2b spacing", acc_cyc[i+1] - acc_cyc[i], 4);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);

        // Reset while a store to 0x20 sits in WAIT on the LATENCY=2 instance.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort in_wait stall", {31'd0, mem_stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort req_ready", {31'd0, req_ready}, 32'd1);
        check("abort mem_stall", {31'd0, mem_stall}, 32'd0);
        check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        access(1'b0, 32'h20, 32'h0, 32'hAAAA5555, 32'h12345678, 1'b0, "post_abort load");

`ifdef DMEM_ERR_EN
        access(1'b0, 32'h10,  32'h0,      32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "err pre load");
        access(1'b0, 32'h400, 32'h0,      32'h0,        32'h0,        1'b1, "err range load");
        access(1'b1, 32'h13,  32'h777777, 32'h0,        32'h0,        1'b1, "err misalign store");
        access(1'b0, 32'h10,  32'h0,      32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "err word4 kept");
        @(negedge clk);
        check("err idle clear", {31'd0, rsp_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
